// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl: feeds each word MSB-first to an external sequence detector, counts its hits and keeps a saturating running total
module seq_scan_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WIDTH-1:0]          word_in,
    input  logic                      word_valid,
    output logic                      word_ready,
    input  logic [CNT_W-1:0]          thresh,
    input  logic                      clear,
    output logic                      det_in,
    output logic                      det_rst,
    input  logic                      det_out,
    output logic [$clog2(WIDTH):0]    result_hits,
    output logic                      result_valid,
    output logic [CNT_W-1:0]          match_cnt,
    output logic                      done
);
    localparam int BW = $clog2(WIDTH);
    localparam int HW = $clog2(WIDTH) + 1;
    localparam int SW = ((CNT_W > HW) ? CNT_W : HW) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_shift;
    logic [BW-1:0]    r_bit_cnt;
    logic [HW-1:0]    r_hits;
    logic [HW-1:0]    r_result_hits;
    logic             r_result_valid;
    logic [CNT_W-1:0] r_match_cnt;
    logic             r_done;
    logic             w_last;
    logic [HW-1:0]    w_hits_final;
    logic [SW-1:0]    w_sum;
    logic [CNT_W-1:0] w_sat;

    assign word_ready   = r_state == IDLE;
    assign det_rst      = r_state == IDLE;
    assign det_in       = (r_state == SHIFT) & r_shift[WIDTH-1];
    assign result_hits  = r_result_hits;
    assign result_valid = r_result_valid;
    assign match_cnt    = r_match_cnt;
    assign done         = r_done;

    // The drain cycle still sees the detector's reaction to the last bit, so fold it into the final count
    assign w_last       = r_state == DRAIN;
    assign w_hits_final = r_hits + HW'(det_out);
    assign w_sum        = SW'(r_match_cnt) + SW'(w_hits_final);
    assign w_sat        = (w_sum > SW'(CNT_MAX)) ? CNT_MAX : w_sum[CNT_W-1:0];

    // Sequencer: load in IDLE, shift WIDTH bits out, then one drain cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (word_valid) begin
                        r_state   <= SHIFT;
                        r_shift   <= word_in;
                        r_bit_cnt <= '0;
                    end
                end
                SHIFT: begin
                    r_shift   <= r_shift << 1;
                    r_bit_cnt <= r_bit_cnt + BW'(1);
                    if (r_bit_cnt == BW'(WIDTH - 1)) r_state <= DRAIN;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Per-word hit counter: restarted on word load, counts detector hits while the word is in flight
    always_ff @(posedge clk) begin
        if (rst) r_hits <= '0;
        else if (r_state == IDLE) r_hits <= word_valid ? '0 : r_hits;
        else if (det_out) r_hits <= r_hits + HW'(1);
    end

    // Result register and its one-cycle valid pulse on leaving DRAIN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result_hits  <= '0;
            r_result_valid <= 1'b0;
        end else begin
            r_result_valid <= w_last;
            if (w_last) r_result_hits <= w_hits_final;
        end
    end

    // Saturating running total and sticky done; clear beats a coincident update
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_match_cnt <= '0;
            r_done      <= 1'b0;
        end else if (w_last) begin
            r_match_cnt <= w_sat;
            if (thresh != '0 && w_sat >= thresh) r_done <= 1'b1;
        end
    end
endmodule

// File: tb/tb_seq_scan_ctrl.sv
// tb_seq_scan_ctrl: detector partner, transaction-level reference model and randomized plus directed stimulus
module tb_seq_scan_ctrl;
    localparam int W    = 8;
    localparam int C    = 8;
    localparam int HW   = $clog2(W) + 1;
    localparam int MAXC = (1 << C) - 1;

    logic          clk = 0, rst = 1, word_valid = 0, clear = 0;
    logic [W-1:0]  word_in = '0;
    logic [C-1:0]  thresh = '0;
    logic          word_ready, det_in, det_rst, det_out, result_valid, done;
    logic [HW-1:0] result_hits;
    logic [C-1:0]  match_cnt;
    int            n_cmp = 0, n_bad = 0;
    bit            armed = 0;

    always #5 clk = ~clk;

    seq_scan_ctrl #(.WIDTH(W), .CNT_W(C)) dut (
        .clk(clk), .rst(rst), .word_in(word_in), .word_valid(word_valid),
        .word_ready(word_ready), .thresh(thresh), .clear(clear),
        .det_in(det_in), .det_rst(det_rst), .det_out(det_out),
        .result_hits(result_hits), .result_valid(result_valid),
        .match_cnt(match_cnt), .done(done)
    );

    // External detector for 1,1,(1)*,0,1: 0 idle, 1 one '1', 2 two+ '1', 3 saw '0', 4 hit (acts as idle)
    int dstate = 0;
    assign det_out = (dstate == 4);
    always @(posedge clk)
        if (det_rst !== 1'b0) dstate <= 0;
        else case (dstate)
            1: dstate <= det_in ? 2 : 0;
            2: dstate <= det_in ? 2 : 3;
            3: dstate <= det_in ? 4 : 0;
            default: dstate <= det_in ? 1 : 0;
        endcase

    // Hits in a word: leftmost non-overlapping windows of 1101, MSB first
    function automatic int ref_hits(logic [W-1:0] w);
        int n = 0, p = 0;
        logic [3:0] win;
        while (p + 4 <= W) begin
            win = w[W-1-p -: 4];
            if (win == 4'b1101) begin n++; p += 4; end
            else p++;
        end
        return n;
    endfunction

    // Transaction model: word accepted in cycle m_T, result in cycle m_T+W+2
    int           cyc = 0, m_T = 0, m_cnt = 0, m_rh = 0, h;
    bit           m_busy = 0, m_rv = 0, m_done = 0, was_busy;
    logic [W-1:0] m_word = '0;
    always @(posedge clk) begin
        was_busy = m_busy;
        cyc++;
        m_rv = 0;
        if (rst) begin
            m_busy = 0; m_cnt = 0; m_done = 0; m_rh = 0;
        end else begin
            if (m_busy && cyc == m_T + W + 2) begin
                h = ref_hits(m_word);
                m_rh = h; m_rv = 1; m_busy = 0;
                if (!clear) begin
                    m_cnt = (m_cnt + h > MAXC) ? MAXC : m_cnt + h;
                    if (thresh != 0 && m_cnt >= thresh) m_done = 1;
                end
            end
            if (clear) begin m_cnt = 0; m_done = 0; end
            if (!was_busy && word_valid) begin m_busy = 1; m_T = cyc - 1; m_word = word_in; end
        end
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model
    always @(negedge clk) if (armed) begin
        int k;
        bit e_di;
        k = cyc - m_T;
        e_di = (m_busy && k >= 1 && k <= W) ? m_word[W-k] : 1'b0;
        chk("word_ready", word_ready, !m_busy);
        chk("det_rst", det_rst, !m_busy);
        chk("det_in", det_in, e_di);
        chk("result_valid", result_valid, m_rv);
        chk("result_hits", result_hits, m_rh);
        chk("match_cnt", match_cnt, m_cnt);
        chk("done", done, m_done);
    end

    task automatic tick(int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send(logic [W-1:0] w);
        int g = 0;
        while (word_ready !== 1'b1 && g < 40) begin tick(); g++; end
        if (word_ready !== 1'b1) chk("ready_timeout", word_ready, 1);
        word_in = w; word_valid = 1;
        tick();
        word_valid = 0;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (result_valid !== 1'b1 && lat < 40) begin tick(); lat++; end
        chk("result_seen", result_valid, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [W-1:0] pats [6] = '{8'hD0, 8'hE8, 8'hDD, 8'hFF, 8'h6D, 8'h00};
    logic [W:0]   seq;
    int           lat, seen;

    initial begin
        #1;
        tick(2);
        armed = 1;
        chk("rst_ready", word_ready, 1);
        chk("rst_det_rst", det_rst, 1);
        chk("rst_det_in", det_in, 0);
        chk("rst_rv", result_valid, 0);
        chk("rst_hits", result_hits, 0);
        chk("rst_cnt", match_cnt, 0);
        chk("rst_done", done, 0);
        rst = 0;
        tick();
        // D0: serial stream, latency and first hit
        send(8'hD0);
        seq = '0;
        for (int i = 0; i < W + 1; i++) begin seq = {seq[W-1:0], det_in}; tick(); end
        chk("d0_seq", seq, 9'b110100000);
        chk("d0_rv", result_valid, 1);
        chk("d0_hits", result_hits, 1);
        chk("d0_cnt", match_cnt, 1);
        tick();
        chk("d0_rv_pulse", result_valid, 0);
        // FF then E8
        send(8'hFF); wait_result(lat);
        chk("ff_lat", lat, W + 1);
        chk("ff_hits", result_hits, 0);
        chk("ff_cnt", match_cnt, 1);
        send(8'hE8); wait_result(lat);
        chk("e8_hits", result_hits, 1);
        chk("e8_cnt", match_cnt, 2);
        // threshold 2 with two D0 words, then FF
        rst = 1; tick(); rst = 0;
        thresh = 2;
        send(8'hD0); wait_result(lat);
        chk("th_done1", done, 0);
        send(8'hD0); wait_result(lat);
        chk("th_done2", done, 1);
        send(8'hFF); wait_result(lat);
        chk("th_done3", done, 1);
        // clear on the DRAIN->IDLE edge
        rst = 1; tick(); rst = 0;
        thresh = 0;
        send(8'hD0); wait_result(lat);
        thresh = 1;
        send(8'hD0);
        tick(W);
        clear = 1; tick(); clear = 0;
        chk("clr_rv", result_valid, 1);
        chk("clr_hits", result_hits, 1);
        chk("clr_cnt", match_cnt, 0);
        chk("clr_done", done, 0);
        // saturation
        thresh = 5;
        for (int i = 0; i < 128; i++) begin send(8'hDD); wait_result(lat); end
        chk("sat_pre", match_cnt, 255);
        send(8'hD0); wait_result(lat);
        chk("sat_hits", result_hits, 1);
        chk("sat_cnt", match_cnt, 255);
        thresh = 0; tick();
        chk("sat_done_sticky", done, 1);
        // reset in the middle of a word
        send(8'hD0);
        tick(3);
        rst = 1; tick(); rst = 0;
        chk("abort_ready", word_ready, 1);
        chk("abort_cnt", match_cnt, 0);
        seen = 0;
        for (int i = 0; i < W + 2; i++) begin if (result_valid) seen++; tick(); end
        chk("abort_no_rv", seen, 0);
        send(8'hD0); wait_result(lat);
        chk("after_abort_lat", lat, W + 1);
        chk("after_abort_cnt", match_cnt, 1);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            word_valid = ($urandom_range(0, 2) == 0);
            word_in = $urandom_range(0, 1) ? pats[$urandom_range(0, 5)] : W'($urandom);
            clear = ($urandom_range(0, 39) == 0);
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 99) == 0) thresh = C'($urandom_range(0, 12));
            tick();
        end
        word_valid = 0; clear = 0; rst = 0;
        tick(W + 4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/seq_scan_ctrl.md
SEQ_SCAN_CTRL -- requirements
Module: seq_scan_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, bits per input word; legal values are 4 to 32.
REQ-002 Parameter: CNT_W, default 8, width of the match counter and threshold.
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst  input  1  reset; synchronous, active-high.
REQ-005 Port: word_in  input  WIDTH  parallel word to scan, MSB-first.
REQ-006 Port: word_valid  input  1  word_in valid.
REQ-007 Port: word_ready  output  1  block can accept a word.
REQ-008 Port: thresh  input  CNT_W  match threshold; 0 disables done.
REQ-009 Port: clear  input  1  synchronous clear of match_cnt and done.
REQ-010 Port: det_in  output  1  serial bit driven to the external sequence detector.
REQ-011 Port: det_rst  output  1  reset to the external detector.
REQ-012 Port: det_out  input  1  detector hit flag.
REQ-013 Port: result_hits  output  $clog2(WIDTH)+1  hits found in the last word.
REQ-014 Port: result_valid  output  1  one-cycle pulse; result_hits is valid.
REQ-015 Port: match_cnt  output  CNT_W  running hit total.
REQ-016 Port: done  output  1  sticky flag; set when match_cnt >= thresh.

Function
REQ-017 The detector partner SHALL be treated as follows: it recognises the sequence 1,1,(1)*,0,1; det_out is a Moore output, high for one cycle on the cycle after the final bit; it restarts from its idle state after a hit.
REQ-018 The FSM SHALL have exactly three states: IDLE, SHIFT and DRAIN.
REQ-019 IDLE behaviour SHALL be: word_ready=1, det_rst=1, det_in=0. When word_valid=1, the block loads word_in into the shift register, clears the bit counter and the per-word hit counter, and moves to SHIFT.
REQ-020 SHIFT behaviour SHALL be: det_in = shift register MSB, and the register shifts left by one each cycle. After WIDTH cycles (bit counter = WIDTH-1), the block moves to DRAIN.
REQ-021 DRAIN SHALL last one cycle with det_in=0, and the block then returns to IDLE.
REQ-022 In SHIFT and DRAIN, det_rst SHALL be 0 and word_ready SHALL be 0; a word_valid in these states is not accepted.
REQ-023 The per-word hit counter SHALL increment on every SHIFT or DRAIN cycle in which det_out=1.
REQ-024 On the DRAIN->IDLE transition, the block SHALL register the final hit count into result_hits and pulse result_valid high for exactly one cycle.
REQ-025 Latency SHALL be fixed: for a word accepted at cycle T, result_valid is high at T+WIDTH+2. The next word can be accepted at T+WIDTH+2, giving a throughput of one word per WIDTH+2 cycles.
REQ-026 On the same DRAIN->IDLE edge, match_cnt SHALL add the word's hit count, saturating at 2^CNT_W-1 with no wrap-around.
REQ-027 done SHALL be set when the updated match_cnt >= thresh and thresh != 0; it stays set until clear or rst.
REQ-028 clear SHALL zero match_cnt and done on the next edge. If clear coincides with a DRAIN->IDLE update, clear wins and that word's hits are dropped from match_cnt; result_hits and result_valid are still produced.
REQ-029 clear SHALL NOT affect the FSM, the shift register or the current word's hit count.
REQ-030 A change to thresh SHALL take effect only at the next match_cnt update; done is never cleared by a thresh change.

Reset
REQ-031 While rst=1, the block SHALL enter IDLE on the next edge and hold the following values: word_ready=1, det_rst=1, det_in=0, result_hits=0, result_valid=0, match_cnt=0, done=0.
REQ-032 An rst during SHIFT or DRAIN SHALL abort the word: no result_valid pulse and no match_cnt update.
REQ-033 rst SHALL take priority over clear and word_valid.

Verification (WIDTH=8, CNT_W=8)
REQ-034 Word 8'hD0 accepted at T -> det_in sequence 1,1,0,1,0,0,0,0 then 0; result_valid at T+10 with result_hits=1; match_cnt=1.
REQ-035 Word 8'hFF -> result_hits=0, match_cnt unchanged; next word 8'hE8 (1,1,1,0,1) -> result_hits=1.
REQ-036 thresh=2, then words 8'hD0 and 8'hD0 -> done=0 after the first word and done=1 on the second result_valid cycle; a following 8'hFF leaves done=1.
REQ-037 clear asserted in the same cycle as the DRAIN->IDLE edge of an 8'hD0 word -> result_hits=1 and result_valid pulses, but match_cnt=0 and done=0.
REQ-038 Preload match_cnt=255 with repeated hits, then send 8'hD0 -> match_cnt stays 255.
REQ-039 rst pulsed at SHIFT bit 4 of word 8'hD0 -> no result_valid, match_cnt=0, word_ready=1 on the next cycle; the next word completes normally after WIDTH+2 cycles.
